if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage in-order LoongArch pipeline, sitting directly upstream of the decode stage. It owns the program counter, issues reads to a synchronous instruction SRAM (1-cycle read latency), and applies branch redirects from decode. It hands `{inst, pc}` to decode under the pipeline valid/allow-in handshake, holding the instruction stable across decode back-pressure.

## Interface
- `RESET_PC`, 32'h1C00_0000, address of the first instruction fetched after reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_to_if_bus`  in  33  `{br_taken, br_target[31:0]}` from decode; `br_taken` is already qualified by decode-valid.
- `id_allow_in`  in  1  decode can accept an instruction this cycle.
- `if_to_id_valid`  out  1  `if_to_id_bus` holds a valid instruction.
- `if_to_id_bus`  out  64  `{inst[31:0], pc[31:0]}`, inst in the upper half.
- `inst_sram_en`  out  1  read request this cycle.
- `inst_sram_we`  out  4  constant 4'b0000.
- `inst_sram_addr`  out  32  byte address of the read.
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_rdata`  in  32  read data, valid the cycle after an accepted request.

## Operation
- State: `if_valid`, `if_pc[31:0]`; with the buffer option, also `buf_valid` and `buf_inst[31:0]`.
- Reset values: `if_valid=0`, `if_pc=RESET_PC-4` (32'h1BFF_FFFC), `buf_valid=0`, `if_to_id_valid=0`, `inst_sram_en=0`.
- `if_ready_go=1` whenever the instruction word is available. This is always true, because data arrives in the cycle `if_valid` rises.
- `if_allow_in = !if_valid | id_allow_in | br_taken`.
- `nextpc = br_taken ? br_target : if_pc + 4`. The addition wraps modulo 2^32. Bits [1:0] are passed through unchecked.
- Request: `inst_sram_en = !reset & if_allow_in` and `inst_sram_addr = nextpc`.
- On a cycle with `if_allow_in=1`: `if_valid <= 1` and `if_pc <= nextpc`.
- Flush: when `br_taken=1`, the instruction currently in IF is wrong-path.
  - `if_to_id_valid` is forced to 0 that cycle.
  - `buf_valid` is cleared.
  - `br_target` is requested.
- `br_taken` may remain high for several cycles while decode is stalled. Each such cycle re-flushes and re-requests `br_target`. This is idempotent: the first instruction passed to decode after `br_taken` falls is the one at `br_target`.
- `if_to_id_valid = if_valid & !br_taken`.
- `inst = buf_valid ? buf_inst : inst_sram_rdata`.
- Handshake: a transfer occurs when `if_to_id_valid & id_allow_in`. Outputs must stay unchanged while valid is high and `id_allow_in` is low.
- Simultaneous `br_taken` and `id_allow_in`: the branch wins. Nothing transfers and the target is fetched.

## Timing
- Cycle 0 after reset release: request `RESET_PC`. Cycle 1: `if_to_id_valid=1` with `pc=RESET_PC`.
- Throughput: one instruction per cycle when decode does not stall.
- Redirect penalty: `br_taken` seen in cycle N gives the target with valid=1 in cycle N+1 (if `br_taken` has fallen). The one wrong-path instruction is dropped.
- Reset asserted mid-operation: all state takes its reset value immediately (asynchronously). Any in-flight SRAM data is ignored.

## Configuration
- `IF_INST_BUF_EN` defined:
  - During a stall (`if_valid & !id_allow_in & !br_taken & !buf_valid`), `buf_inst <= inst_sram_rdata` and `buf_valid <= 1`.
  - `buf_valid` clears on a transfer, a flush, or reset.
  - While stalled, `inst_sram_en=0`.
- `IF_INST_BUF_EN` undefined:
  - No buffer exists.
  - While stalled, the stage re-reads the held PC every cycle: `inst_sram_en=1` and `inst_sram_addr=if_pc`, so `rdata` stays valid.
  - `inst` is always `inst_sram_rdata`.
- Externally visible `if_to_id_*` behaviour is identical in both builds.

## Test plan
- Reset then free-run with `id_allow_in=1` and a SRAM model returning `addr`: the first three transfers carry pc/inst 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles.
- Stall `id_allow_in=0` for 3 cycles while holding pc 0x1C000004 (SRAM model corrupts `rdata` when `en=0`): outputs hold that pc/inst unchanged, then it transfers exactly once and the next is 0x1C000008. Run in both builds.
- One-cycle `br_taken=1` with target 0x1C000100 while IF holds 0x1C000008: no transfer of 0x1C000008, and the next valid output is pc 0x1C000100.
- `br_taken` held 3 cycles with `id_allow_in=0`, target 0x1C000200: valid stays 0 throughout, then pc 0x1C000200 is delivered once.
- `br_taken` and `id_allow_in` high in the same cycle: no transfer occurs.
- Reset asserted mid-stream while the PC is at 0x1C000010: valid drops immediately, and after release the first output is 0x1C000000 again.

Source files
------------

// File: rtl/if_stage_if.sv
// Port bundle for if_stage: decode-side valid/allow-in handshake plus the
// synchronous instruction SRAM read port. master = fetch stage, slave = environment.
interface if_stage_if;
  logic [32:0] id_to_if_bus;
  logic        id_allow_in;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  id_to_if_bus, id_allow_in, inst_sram_rdata,
    output if_to_id_valid, if_to_id_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output id_to_if_bus, id_allow_in, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle synchronous SRAM, applies
// decode redirects. Define IF_INST_BUF_EN to hold stalled instructions in a local buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);
  localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_ready_go, if_allow_in, stall, xfer;
  logic [31:0] nextpc, inst;

  assign {br_taken, br_target} = bus.id_to_if_bus;

  // SRAM data lands in the same cycle if_valid rises, so the word is always ready.
  assign if_ready_go = 1'b1;
  assign if_allow_in = !if_valid_q || bus.id_allow_in || br_taken;
  assign stall       = if_valid_q && !bus.id_allow_in && !br_taken;
  assign nextpc      = br_taken ? br_target : if_pc_q + 32'd4;

  assign bus.if_to_id_valid = if_valid_q && if_ready_go && !br_taken;
  assign xfer               = bus.if_to_id_valid && bus.id_allow_in;
  assign bus.if_to_id_bus   = {inst, if_pc_q};

  assign bus.inst_sram_we    = 4'b0000;
  assign bus.inst_sram_wdata = 32'd0;

  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if (if_allow_in) begin
      if_valid_d = 1'b1;
      if_pc_d    = nextpc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= PC_INIT;
    end else begin
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
    end
  end

`ifdef IF_INST_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  // Capture on the first stall cycle only; later stall cycles issue no read.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (br_taken || xfer) begin
      buf_valid_d = 1'b0;
    end else if (stall && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = bus.inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign inst               = buf_valid_q ? buf_inst_q : bus.inst_sram_rdata;
  assign bus.inst_sram_en   = !reset && if_allow_in;
  assign bus.inst_sram_addr = nextpc;
`else
  // No buffer: keep re-reading the held PC so rdata stays valid across a stall.
  assign inst               = bus.inst_sram_rdata;
  assign bus.inst_sram_en   = !reset && (if_allow_in || stall);
  assign bus.inst_sram_addr = if_allow_in ? nextpc : if_pc_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed stimulus pushes expected {inst,pc}
// transfers; a negedge monitor pops and compares on every handshake.
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] exp_q[$];

  if_stage_if bus();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // SRAM model returns the address as data; unrequested cycles return garbage.
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? bus.inst_sram_addr : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, pc};
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.if_to_id_valid && bus.id_allow_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL xfer_unexpected got=%h exp=none t=%0t", bus.if_to_id_bus, $time);
      end else begin
        chk("xfer", bus.if_to_id_bus, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input logic allow, input logic br, input logic [31:0] tgt);
    @(posedge clk); #1;
    bus.id_allow_in  = allow;
    bus.id_to_if_bus = {br, tgt};
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset            = 1'b1;
    bus.id_allow_in  = 1'b0;
    bus.id_to_if_bus = 33'd0;
    @(negedge clk);
  endtask

  task automatic rel_reset();
    @(posedge clk); #1;
    reset            = 1'b0;
    bus.id_allow_in  = 1'b1;
    bus.id_to_if_bus = 33'd0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.id_allow_in  = 1'b0;
    bus.id_to_if_bus = 33'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.if_to_id_valid), 64'd0);
    chk("rst_en",    64'(bus.inst_sram_en),   64'd0);
    chk("we_zero",   64'(bus.inst_sram_we),   64'd0);
    chk("wdata_zero", 64'(bus.inst_sram_wdata), 64'd0);

    // Free-run, then a one-cycle branch with allow_in also high
    exp_q.push_back(ent(32'h1C00_0000));
    exp_q.push_back(ent(32'h1C00_0004));
    exp_q.push_back(ent(32'h1C00_0100));
    rel_reset();                                   // cycle 0
    chk("c0_valid", 64'(bus.if_to_id_valid), 64'd0);
    chk("c0_en",    64'(bus.inst_sram_en),   64'd1);
    chk("c0_addr",  64'(bus.inst_sram_addr), 64'h1C00_0000);
    tick(1'b1, 1'b0, 32'd0);                       // 0x1C000000 transfers
    chk("c1_valid", 64'(bus.if_to_id_valid), 64'd1);
    tick(1'b1, 1'b0, 32'd0);                       // 0x1C000004 transfers
    chk("c2_valid", 64'(bus.if_to_id_valid), 64'd1);
    tick(1'b1, 1'b1, 32'h1C00_0100);               // IF holds 0x..08, flushed
    chk("br_valid", 64'(bus.if_to_id_valid), 64'd0);
    chk("br_addr",  64'(bus.inst_sram_addr), 64'h1C00_0100);
    chk("br_en",    64'(bus.inst_sram_en),   64'd1);
    tick(1'b1, 1'b0, 32'd0);                       // target transfers
    tick(1'b0, 1'b0, 32'd0);
    chk("post_br_pc", bus.if_to_id_bus, ent(32'h1C00_0104));

    // Stall three cycles on 0x1C000004
    do_reset();
    exp_q.push_back(ent(32'h1C00_0000));
    exp_q.push_back(ent(32'h1C00_0004));
    exp_q.push_back(ent(32'h1C00_0008));
    rel_reset();
    tick(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'd0);
      chk("stall_valid", 64'(bus.if_to_id_valid), 64'd1);
      chk("stall_bus",   bus.if_to_id_bus, ent(32'h1C00_0004));
    end
    tick(1'b1, 1'b0, 32'd0);                       // 0x..04 transfers once
    tick(1'b1, 1'b0, 32'd0);                       // 0x..08

    // Branch held three cycles while decode stalls
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 32'h1C00_0200);
      chk("brhold_valid", 64'(bus.if_to_id_valid), 64'd0);
    end
    exp_q.push_back(ent(32'h1C00_0200));
    tick(1'b1, 1'b0, 32'd0);
    chk("brhold_tgt", bus.if_to_id_bus, ent(32'h1C00_0200));
    tick(1'b0, 1'b0, 32'd0);
    chk("brhold_next", bus.if_to_id_bus, ent(32'h1C00_0204));

    // Reset mid-stream at 0x1C000010
    do_reset();
    exp_q.push_back(ent(32'h1C00_0000));
    exp_q.push_back(ent(32'h1C00_0004));
    exp_q.push_back(ent(32'h1C00_0008));
    exp_q.push_back(ent(32'h1C00_000C));
    rel_reset();
    repeat (4) tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("pre_rst_valid", 64'(bus.if_to_id_valid), 64'd1);
    chk("pre_rst_pc",    64'(bus.if_to_id_bus[31:0]), 64'h1C00_0010);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.if_to_id_valid), 64'd0);
    chk("async_rst_en",    64'(bus.inst_sram_en),   64'd0);
    exp_q.push_back(ent(32'h1C00_0000));
    rel_reset();
    tick(1'b1, 1'b0, 32'd0);
    chk("after_rst_pc", bus.if_to_id_bus, ent(32'h1C00_0000));
    tick(1'b0, 1'b0, 32'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
